// File: rtl/xgriscv_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand widths, funct3 operation codes and FSM state encoding.
package xgriscv_muldiv_pkg;

  localparam int XLEN        = 32;
  localparam int RFIDX_WIDTH = 5;
  localparam int ITERS       = XLEN;
  localparam int CNT_W       = $clog2(ITERS);

  // funct3 encodings of the RV32M instructions
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  // Two's-complement negate when requested
  function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/xgriscv_muldiv_iter_core.sv
// Datapath of the iterative unit: holds the shift-add accumulator and the
// restoring-divide quotient/remainder, advancing one step per enable.
// Both loops step in lockstep on the same magnitudes; the top picks the
// one that matches the latched operation.  The next-step values are exported
// so the top can register the final result in the same edge as the last step.
module muldiv_iter_core
  import xgriscv_muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                en,
  input  logic [XLEN-1:0]     opa,       // |a|: multiplicand / dividend
  input  logic [XLEN-1:0]     opb,       // |b|: multiplier / divisor
  output logic [2*XLEN-1:0]   acc_next,
  output logic [XLEN-1:0]     quot_next,
  output logic [XLEN-1:0]     rem_next
);

  logic [XLEN-1:0]   opa_reg;
  logic [XLEN-1:0]   opb_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   quot_reg;
  logic [XLEN-1:0]   rem_reg;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;

  // One multiply step and one restoring-divide step
  always_comb begin
    // Add the multiplicand to the upper half when the current multiplier bit is set,
    // then shift the whole accumulator right by one (carry enters at the top).
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opa_reg} : '0);
    acc_next  = {mul_sum, acc_reg[XLEN-1:1]};

    // Shift the next dividend bit into the remainder and try subtracting the divisor.
    // The remainder is always below the divisor, so XLEN+1 bits hold the shifted value
    // and a set top bit of the difference means the subtraction went negative.
    rem_shift = {rem_reg, quot_reg[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opb_reg};
    if (!rem_diff[XLEN]) begin
      rem_next  = rem_diff[XLEN-1:0];
      quot_next = {quot_reg[XLEN-2:0], 1'b1};
    end else begin
      rem_next  = rem_shift[XLEN-1:0];
      quot_next = {quot_reg[XLEN-2:0], 1'b0};
    end
  end

  // Operand load and per-step state update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa_reg  <= '0;
      opb_reg  <= '0;
      acc_reg  <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
    end else if (load) begin
      opa_reg  <= opa;
      opb_reg  <= opb;
      acc_reg  <= {{XLEN{1'b0}}, opb};
      quot_reg <= opa;
      rem_reg  <= '0;
    end else if (en) begin
      acc_reg  <= acc_next;
      quot_reg <= quot_next;
      rem_reg  <= rem_next;
    end
  end

endmodule

// File: rtl/xgriscv_muldiv.sv
// Iterative RV32M multiply/divide unit. Launches on start in IDLE, runs
// ITERS steps, then issues one regfile write (we/wa/wd) in a single DONE cycle.
// Divide-by-zero and signed overflow bypass the loop and finish next cycle.
module xgriscv_muldiv
  import xgriscv_muldiv_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   flush,
  input  logic [2:0]             op,
  input  logic [XLEN-1:0]        a,
  input  logic [XLEN-1:0]        b,
  input  logic [RFIDX_WIDTH-1:0] rd,
  output logic                   busy,
  output logic                   done,
  output logic                   we,
  output logic [RFIDX_WIDTH-1:0] wa,
  output logic [XLEN-1:0]        wd
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERS - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e              state_reg, state_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  md_op_e                 op_reg;
  logic [RFIDX_WIDTH-1:0] rd_reg;
  logic                   neg_q_reg;   // product / quotient must be negated
  logic                   neg_r_reg;   // remainder must be negated (dividend sign)
  logic [RFIDX_WIDTH-1:0] wa_reg;
  logic [XLEN-1:0]        wd_reg;

  md_op_e                 op_in;
  logic                   a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic                   div_by_zero, div_ovf, special;
  logic [XLEN-1:0]        special_result;
  logic                   capture, finish;

  logic [2*XLEN-1:0]      acc_next;
  logic [XLEN-1:0]        quot_next, rem_next;
  logic [2*XLEN-1:0]      prod_fix;
  logic [XLEN-1:0]        run_result;

  // Operand decode: signedness, magnitudes and the cases that skip the loop
  always_comb begin
    op_in    = md_op_e'(op);
    a_signed = (op_in == MD_MULH) || (op_in == MD_MULHSU) || (op_in == MD_DIV) || (op_in == MD_REM);
    b_signed = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
    a_neg    = a_signed && a[XLEN-1];
    b_neg    = b_signed && b[XLEN-1];
    a_mag    = negate_if(a_neg, a);
    b_mag    = negate_if(b_neg, b);

    div_by_zero = op_in[2] && (b == '0);
    div_ovf     = ((op_in == MD_DIV) || (op_in == MD_REM)) && (a == INT_MIN) && (b == '1);
    special     = div_by_zero || div_ovf;

    // op[1] selects the remainder flavour among the divides
    if (div_by_zero) special_result = op_in[1] ? a : '1;
    else             special_result = op_in[1] ? '0 : INT_MIN;
  end

  // FSM next state, step counter and launch/finish strobes
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start && !flush) begin
          capture    = 1'b1;
          count_next = '0;
          state_next = special ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_next = S_IDLE;
        end else if (count_reg == LAST_STEP) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  muldiv_iter_core u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (capture && !special),
    .en        (state_reg == S_RUN),
    .opa       (a_mag),
    .opb       (b_mag),
    .acc_next  (acc_next),
    .quot_next (quot_next),
    .rem_next  (rem_next)
  );

  // Sign fix-up of the final step's values and selection by operation
  always_comb begin
    prod_fix = neg_q_reg ? -acc_next : acc_next;
    if (!op_reg[2])
      run_result = (op_reg == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      run_result = op_reg[1] ? negate_if(neg_r_reg, rem_next) : negate_if(neg_q_reg, quot_next);
  end

  // State, latched operation info and write-port registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      op_reg    <= MD_MUL;
      rd_reg    <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      wa_reg    <= '0;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (capture) begin
        op_reg    <= op_in;
        rd_reg    <= rd;
        neg_q_reg <= a_neg ^ b_neg;
        neg_r_reg <= a_neg;
      end
      if (capture && special) begin
        wd_reg <= special_result;
        wa_reg <= rd;
      end else if (finish) begin
        wd_reg <= run_result;
        wa_reg <= rd_reg;
      end
    end
  end

  // A flush in the DONE cycle suppresses the pulse and the write
  assign busy = (state_reg != S_IDLE);
  assign done = (state_reg == S_DONE) && !flush;
  assign we   = done && (wa_reg != '0);
  assign wa   = wa_reg;
  assign wd   = wd_reg;

endmodule

// File: tb/tb_xgriscv_muldiv.sv
// Self-checking bench for xgriscv_muldiv: directed RV32M cases, boundary
// divides, flush/reset/start-while-busy behaviour and randomized operations
// checked against a plain-arithmetic reference model.
module tb_xgriscv_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  xgriscv_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .flush (flush),
    .op    (op),
    .a     (a),
    .b     (b),
    .rd    (rd),
    .busy  (busy),
    .done  (done),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference results straight from the RV32M definitions
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy, p;
    int              xi, yi;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    xi = $signed(x);
    yi = $signed(y);
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        if (x == MIN32 && y == 32'hFFFF_FFFF) return MIN32;
        return 32'(xi / yi);
      end
      3'd5: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 32'h0) return x;
        if (x == MIN32 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(xi % yi);
      end
      default: begin
        if (y == 32'h0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 32'h0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == MIN32 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Launch one operation and check latency, busy, write port and the pulse shape.
  // pulse_at != 0 re-asserts start with unrelated operands after that many edges.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r, input int pulse_at);
    logic [31:0] expv;
    int          lat, edges;
    bit          busy_ok, seen;
    expv = ref_result(o, x, y);
    lat  = ref_latency(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; rd = r; start = 1'b1;
    @(posedge clk);
    edges = 1; busy_ok = 1'b1; seen = 1'b0;
    while (!seen && edges <= 40) begin
      @(negedge clk);
      start = 1'b0;
      if (pulse_at != 0 && edges == pulse_at) begin
        start = 1'b1; op = ~o; a = $urandom; b = $urandom; rd = ~r;
      end
      if (done) seen = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        @(posedge clk);
        edges++;
      end
    end
    start = 1'b0;
    $display("op %s: op=%0d a=%h b=%h rd=%0d -> wd=%h wa=%0d we=%b after %0d edges (want %h in %0d)",
             tag, o, x, y, r, wd, wa, we, edges, expv, lat);
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(edges), 32'(lat));
    check({tag, ".busy_during"}, 32'(busy_ok && busy), 32'd1);
    check({tag, ".wd"}, wd, expv);
    check({tag, ".wa"}, 32'(wa), 32'(r));
    check({tag, ".we"}, 32'(we), 32'(r != 5'd0));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".we_pulse"}, 32'(we), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
    check({tag, ".wd_hold"}, wd, expv);
  endtask

  initial begin
    bit          got_done;
    logic [31:0] rx, ry;

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0; rd = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.we", 32'(we), 32'd0);
    check("reset.wa", 32'(wa), 32'd0);
    check("reset.wd", wd, 32'd0);
    reset = 1'b0;

    // Directed arithmetic
    run_op("mul_7_m3",     3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  0);
    run_op("mulh_min_min", 3'd1, MIN32,        MIN32,         5'd6,  0);
    run_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
    run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0);
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,        5'd9,  0);
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,        5'd10, 0);
    run_op("divu_100_7",   3'd5, 32'd100,      32'd7,         5'd11, 0);
    run_op("remu_100_7",   3'd7, 32'd100,      32'd7,         5'd12, 0);

    // Boundary divides finish in one cycle
    run_op("div_by0",      3'd4, 32'd5,        32'd0,         5'd13, 0);
    run_op("rem_by0",      3'd6, 32'd5,        32'd0,         5'd14, 0);
    run_op("divu_by0",     3'd5, 32'd9,        32'd0,         5'd15, 0);
    run_op("remu_by0",     3'd7, 32'd9,        32'd0,         5'd16, 0);
    run_op("div_ovf",      3'd4, MIN32,        32'hFFFF_FFFF, 5'd17, 0);
    run_op("rem_ovf",      3'd6, MIN32,        32'hFFFF_FFFF, 5'd18, 0);

    // Flush mid-RUN: no done or write, then a fresh op completes correctly
    @(negedge clk);
    op = 3'd0; a = 32'd123; b = 32'd456; rd = 5'd3; start = 1'b1;
    @(posedge clk);
    repeat (9) begin @(negedge clk); start = 1'b0; @(posedge clk); end
    @(negedge clk);
    flush = 1'b1;
    check("flush_run.done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_run.busy", 32'(busy), 32'd0);
    got_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done || we) got_done = 1'b1; end
    check("flush_run.no_done", 32'(got_done), 32'd0);
    $display("flush in RUN: busy=%b done_seen_after=%b", busy, got_done);
    run_op("after_flush", 3'd1, 32'hFFFF_FF00, 32'd1000, 5'd4, 0);

    // Flush in the DONE cycle suppresses done/we
    @(negedge clk);
    op = 3'd4; a = 32'd5; b = 32'd0; rd = 5'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    #1;
    check("flush_done.busy", 32'(busy), 32'd1);
    check("flush_done.done", 32'(done), 32'd0);
    check("flush_done.we", 32'(we), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_done.idle", 32'(busy), 32'd0);
    $display("flush in DONE: done=%b we=%b busy=%b", done, we, busy);

    // start together with flush in IDLE: nothing launches
    @(negedge clk);
    op = 3'd4; a = 32'd1; b = 32'd0; rd = 5'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush.busy", 32'(busy), 32'd0);
    check("start_flush.done", 32'(done), 32'd0);
    $display("start+flush in IDLE: busy=%b done=%b", busy, done);

    // start pulsed mid-RUN is ignored
    run_op("mid_start", 3'd6, 32'hFFFF_FC18, 32'd7, 5'd21, 5);

    // Asynchronous reset between edges mid-RUN
    @(negedge clk);
    op = 3'd0; a = 32'd77; b = 32'd99; rd = 5'd9; start = 1'b1;
    @(posedge clk);
    repeat (14) begin @(negedge clk); start = 1'b0; @(posedge clk); end
    @(negedge clk);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset_run.busy", 32'(busy), 32'd0);
    check("reset_run.done", 32'(done), 32'd0);
    check("reset_run.we", 32'(we), 32'd0);
    check("reset_run.wd", wd, 32'd0);
    $display("reset mid-RUN: busy=%b done=%b we=%b wd=%h", busy, done, we, wd);
    @(negedge clk);
    reset = 1'b0;

    // rd == 0: runs normally, done pulses, no write enable
    run_op("rd0_mul", 3'd0, 32'd3, 32'd4, 5'd0, 0);
    run_op("rd0_div0", 3'd5, 32'd3, 32'd0, 5'd0, 0);

    // Randomized operations with corner-value bias
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: rx = 32'h0;
        1: rx = MIN32;
        2: rx = 32'hFFFF_FFFF;
        3: rx = $urandom_range(0, 20);
        default: rx = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: ry = 32'h0;
        1: ry = MIN32;
        2: ry = 32'hFFFF_FFFF;
        3: ry = $urandom_range(0, 20);
        default: ry = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), rx, ry, 5'($urandom_range(0, 31)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
